// File: rtl/light_pkg.sv
// Shared definitions for the light display sequencing path: index width,
// default wrap point, controller state encoding and the load clamp helper.
package light_pkg;

  localparam int SEL_W       = 6;
  localparam int SEL_MAX_DEF = 59;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } state_e;

  function automatic logic [SEL_W-1:0] sel_clamp(input logic [SEL_W-1:0] v,
                                                 input logic [SEL_W-1:0] max_v);
    return (v > max_v) ? max_v : v;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Step-rate prescaler: counts 0..TICK_DIV-1 while enabled, clear wins over enable.
// Terminal count is a combinational decode of the current count.
module tick_prescaler #(
  parameter int TICK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic tc_o
);

  localparam int            PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pcnt_q, pcnt_d;

  assign tc_o = (pcnt_q == LAST);

  always_comb begin
    pcnt_d = pcnt_q;
    if (clr_i) begin
      pcnt_d = '0;
    end else if (en_i) begin
      pcnt_d = tc_o ? '0 : pcnt_q + PW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/light_step_sequencer.sv
// Generates the shared sel index for the light decoders, stepping 0..SEL_MAX at
// the prescaled rate, with start/pause/stop/load control. All outputs registered.
module light_step_sequencer
  import light_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int SEL_MAX  = SEL_MAX_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             pause_i,
  input  logic             stop_i,
  input  logic             load_i,
  input  logic [SEL_W-1:0] load_val_i,
  output logic [SEL_W-1:0] sel_o,
  output logic             step_o,
  output logic             wrap_o,
  output logic             busy_o,
  output logic [1:0]       state_o
);

  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(SEL_MAX);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;
  logic             busy_q, busy_d;
  logic             pc_en, pc_clr, pc_tc;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (pc_en),
    .clr_i (pc_clr),
    .tc_o  (pc_tc)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    step_d  = 1'b0;
    wrap_d  = 1'b0;
    pc_en   = 1'b0;
    pc_clr  = 1'b0;
    if (stop_i) begin
      state_d = ST_IDLE;
      sel_d   = '0;
      pc_clr  = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          pc_clr = 1'b1;
          if (start_i && !pause_i) state_d = ST_RUN;
        end
        ST_RUN: begin
          // A pause or load cycle never advances; load reseeds the prescaler below.
          if (pause_i) begin
            state_d = ST_PAUSED;
          end else if (!load_i) begin
            pc_en = 1'b1;
            if (pc_tc) begin
              step_d = 1'b1;
              if (sel_q == SEL_LAST) begin
                sel_d  = '0;
                wrap_d = 1'b1;
              end else begin
                sel_d = sel_q + 1'b1;
              end
            end
          end
        end
        ST_PAUSED: begin
          if (start_i && !pause_i) state_d = ST_RUN;
        end
        default: state_d = ST_IDLE;
      endcase
      if (load_i) begin
        sel_d  = sel_clamp(load_val_i, SEL_LAST);
        pc_clr = 1'b1;
      end
    end
    busy_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
      busy_q  <= busy_d;
    end
  end

  assign sel_o   = sel_q;
  assign step_o  = step_q;
  assign wrap_o  = wrap_q;
  assign busy_o  = busy_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_light_step_sequencer.sv
// Bench for light_step_sequencer: instance A (TICK_DIV=4, SEL_MAX=59) and
// instance B (TICK_DIV=1, SEL_MAX=3) against an integer reference model.
module tb_light_step_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst_v, start_v, pause_v, stop_v, load_v;
  logic [5:0] lv_a, lv_b;

  logic [5:0] sel_a, sel_b;
  logic       step_a, step_b, wrap_a, wrap_b, busy_a, busy_b;
  logic [1:0] state_a, state_b;

  wire logic [10:0] obs_a = {sel_a, step_a, wrap_a, busy_a, state_a};
  wire logic [10:0] obs_b = {sel_b, step_b, wrap_b, busy_b, state_b};

  light_step_sequencer #(.TICK_DIV(4), .SEL_MAX(59)) dut_a (
    .clk_i(clk), .rst_i(rst_v[0]), .start_i(start_v[0]), .pause_i(pause_v[0]),
    .stop_i(stop_v[0]), .load_i(load_v[0]), .load_val_i(lv_a),
    .sel_o(sel_a), .step_o(step_a), .wrap_o(wrap_a), .busy_o(busy_a), .state_o(state_a)
  );

  light_step_sequencer #(.TICK_DIV(1), .SEL_MAX(3)) dut_b (
    .clk_i(clk), .rst_i(rst_v[1]), .start_i(start_v[1]), .pause_i(pause_v[1]),
    .stop_i(stop_v[1]), .load_i(load_v[1]), .load_val_i(lv_b),
    .sel_o(sel_b), .step_o(step_b), .wrap_o(wrap_b), .busy_o(busy_b), .state_o(state_b)
  );

  // Reference model: 0=idle, 1=running, 2=paused; pc counts cycles into the current step.
  int TD[2] = '{4, 1};
  int SM[2] = '{59, 3};
  int m_st[2], m_sel[2], m_pc[2];
  bit m_step[2], m_wrap[2];
  int total = 0;
  int bad   = 0;

  task automatic model_upd(input int k);
    int lv;
    lv = (k == 0) ? int'(lv_a) : int'(lv_b);
    m_step[k] = 0;
    m_wrap[k] = 0;
    if (rst_v[k]) begin
      m_st[k] = 0; m_sel[k] = 0; m_pc[k] = 0;
    end else if (stop_v[k]) begin
      m_st[k] = 0; m_sel[k] = 0; m_pc[k] = 0;
    end else begin
      if (m_st[k] == 1 && !pause_v[k] && !load_v[k]) begin
        m_pc[k] = m_pc[k] + 1;
        if (m_pc[k] == TD[k]) begin
          m_pc[k]   = 0;
          m_step[k] = 1;
          m_wrap[k] = (m_sel[k] == SM[k]);
          m_sel[k]  = (m_sel[k] + 1) % (SM[k] + 1);
        end
      end
      if (load_v[k]) begin
        m_sel[k] = (lv > SM[k]) ? SM[k] : lv;
        m_pc[k]  = 0;
      end
      if (m_st[k] == 0) begin
        m_pc[k] = 0;
        if (start_v[k] && !pause_v[k]) m_st[k] = 1;
      end else if (m_st[k] == 1) begin
        if (pause_v[k]) m_st[k] = 2;
      end else if (start_v[k] && !pause_v[k]) begin
        m_st[k] = 1;
      end
    end
  endtask

  function automatic logic [10:0] exp_vec(input int k);
    logic [5:0] s;
    logic [1:0] st;
    s  = 6'(m_sel[k]);
    st = 2'(m_st[k]);
    return {s, m_step[k], m_wrap[k], (m_st[k] == 1), st};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_upd(0);
    model_upd(1);
    #1;
  endtask

  task automatic idle_inputs();
    rst_v = '0; start_v = '0; pause_v = '0; stop_v = '0; load_v = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_v = 2'b11; start_v = 2'b11;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (obs_a !== 11'd0) begin bad++; $display("FAIL reset_a cyc%0d: got %h want %h", i, obs_a, 11'd0); end
      total++;
      if (obs_b !== 11'd0) begin bad++; $display("FAIL reset_b cyc%0d: got %h want %h", i, obs_b, 11'd0); end
    end
    idle_inputs();
    tick();
    total++;
    if (obs_a !== exp_vec(0)) begin bad++; $display("FAIL reset_idle: got %h want %h", obs_a, exp_vec(0)); end
  endtask

  task automatic test_free_run();
    int steps, wraps;
    steps = 0; wraps = 0;
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    total++;
    if (state_a !== 2'd1 || busy_a !== 1'b1 || sel_a !== 6'd0) begin
      bad++; $display("FAIL free_start: got st=%0d busy=%b sel=%0d want st=1 busy=1 sel=0", state_a, busy_a, sel_a);
    end
    for (int i = 1; i <= 244; i++) begin
      tick();
      total++;
      if (obs_a !== exp_vec(0)) begin bad++; $display("FAIL free_run cyc%0d: got %h want %h", i, obs_a, exp_vec(0)); end
      steps += int'(step_a);
      wraps += int'(wrap_a);
      if (i == 4) begin
        total++;
        if (sel_a !== 6'd1 || step_a !== 1'b1) begin bad++; $display("FAIL free_first_step: got sel=%0d step=%b want sel=1 step=1", sel_a, step_a); end
      end
      if (i == 8) begin
        total++;
        if (sel_a !== 6'd2) begin bad++; $display("FAIL free_second_step: got sel=%0d want 2", sel_a); end
      end
      if (i == 240) begin
        total++;
        if (sel_a !== 6'd0 || wrap_a !== 1'b1) begin bad++; $display("FAIL free_wrap: got sel=%0d wrap=%b want sel=0 wrap=1", sel_a, wrap_a); end
      end
    end
    total++;
    if (steps != 61 || wraps != 1) begin bad++; $display("FAIL free_counts: got steps=%0d wraps=%0d want 61 1", steps, wraps); end
  endtask

  task automatic test_pause_resume();
    for (int n = 0; n < 300 && !(m_sel[0] == 5 && m_pc[0] == 2); n++) begin
      tick();
      total++;
      if (obs_a !== exp_vec(0)) begin bad++; $display("FAIL pause_seek: got %h want %h", obs_a, exp_vec(0)); end
    end
    total++;
    if (!(m_sel[0] == 5 && m_pc[0] == 2)) begin bad++; $display("FAIL pause_timeout: got sel=%0d want 5", m_sel[0]); end
    pause_v[0] = 1'b1;
    tick();
    pause_v[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (sel_a !== 6'd5 || state_a !== 2'd2 || step_a !== 1'b0) begin
        bad++; $display("FAIL pause_hold cyc%0d: got sel=%0d st=%0d want sel=5 st=2", i, sel_a, state_a);
      end
    end
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    total++;
    if (state_a !== 2'd1 || sel_a !== 6'd5) begin bad++; $display("FAIL resume_edge: got st=%0d sel=%0d want 1 5", state_a, sel_a); end
    tick();
    total++;
    if (sel_a !== 6'd5 || step_a !== 1'b0) begin bad++; $display("FAIL resume_r1: got sel=%0d step=%b want 5 0", sel_a, step_a); end
    tick();
    total++;
    if (sel_a !== 6'd6 || step_a !== 1'b1) begin bad++; $display("FAIL resume_r2: got sel=%0d step=%b want 6 1", sel_a, step_a); end
  endtask

  task automatic test_load_clamp();
    tick();
    load_v[0] = 1'b1; lv_a = 6'd57;
    tick();
    load_v[0] = 1'b0;
    total++;
    if (sel_a !== 6'd57 || step_a !== 1'b0 || wrap_a !== 1'b0) begin
      bad++; $display("FAIL load_57: got sel=%0d step=%b wrap=%b want 57 0 0", sel_a, step_a, wrap_a);
    end
    for (int i = 1; i <= 4; i++) begin
      tick();
      total++;
      if (sel_a !== ((i == 4) ? 6'd58 : 6'd57) || step_a !== (i == 4)) begin
        bad++; $display("FAIL load_next cyc%0d: got sel=%0d step=%b want %0d %b", i, sel_a, step_a, (i == 4) ? 58 : 57, (i == 4));
      end
    end
    load_v[0] = 1'b1; lv_a = 6'd63;
    tick();
    load_v[0] = 1'b0;
    total++;
    if (sel_a !== 6'd59) begin bad++; $display("FAIL load_clamp: got sel=%0d want 59", sel_a); end
    repeat (4) tick();
    total++;
    if (sel_a !== 6'd0 || wrap_a !== 1'b1 || step_a !== 1'b1) begin
      bad++; $display("FAIL clamp_wrap: got sel=%0d wrap=%b step=%b want 0 1 1", sel_a, wrap_a, step_a);
    end
  endtask

  task automatic test_priority();
    for (int n = 0; n < 300 && m_sel[0] != 12; n++) tick();
    total++;
    if (sel_a !== 6'd12) begin bad++; $display("FAIL prio_seek: got sel=%0d want 12", sel_a); end
    stop_v[0] = 1'b1; load_v[0] = 1'b1; lv_a = 6'd30;
    tick();
    idle_inputs();
    total++;
    if (obs_a !== 11'd0) begin bad++; $display("FAIL prio_stop_load: got %h want %h", obs_a, 11'd0); end
    start_v[0] = 1'b1; pause_v[0] = 1'b1;
    tick();
    idle_inputs();
    total++;
    if (state_a !== 2'd0 || busy_a !== 1'b0) begin bad++; $display("FAIL prio_start_pause: got st=%0d busy=%b want 0 0", state_a, busy_a); end
    start_v[0] = 1'b1; load_v[0] = 1'b1; lv_a = 6'd20;
    tick();
    idle_inputs();
    total++;
    if (state_a !== 2'd1 || sel_a !== 6'd20 || step_a !== 1'b0) begin
      bad++; $display("FAIL prio_load_start: got st=%0d sel=%0d want 1 20", state_a, sel_a);
    end
  endtask

  task automatic test_fast();
    logic [5:0] want_sel [5];
    want_sel = '{6'd1, 6'd2, 6'd3, 6'd0, 6'd1};
    rst_v[1] = 1'b1;
    tick();
    rst_v[1] = 1'b0; start_v[1] = 1'b1;
    tick();
    start_v[1] = 1'b0;
    total++;
    if (state_b !== 2'd1 || sel_b !== 6'd0 || step_b !== 1'b0) begin
      bad++; $display("FAIL fast_start: got st=%0d sel=%0d step=%b want 1 0 0", state_b, sel_b, step_b);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (sel_b !== want_sel[i] || step_b !== 1'b1 || wrap_b !== (i == 3)) begin
        bad++; $display("FAIL fast_seq cyc%0d: got sel=%0d step=%b wrap=%b want %0d 1 %b", i, sel_b, step_b, wrap_b, want_sel[i], (i == 3));
      end
    end
  endtask

  task automatic test_random();
    rst_v = 2'b11;
    tick();
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 2; k++) begin
        rst_v[k]   = ($urandom_range(199) == 0);
        stop_v[k]  = ($urandom_range(59) == 0);
        load_v[k]  = ($urandom_range(24) == 0);
        pause_v[k] = ($urandom_range(11) == 0);
        start_v[k] = ($urandom_range(5) == 0);
      end
      lv_a = 6'($urandom_range(63));
      lv_b = 6'($urandom_range(63));
      tick();
      total++;
      if (obs_a !== exp_vec(0)) begin bad++; $display("FAIL rand_a cyc%0d: got %h want %h", i, obs_a, exp_vec(0)); end
      total++;
      if (obs_b !== exp_vec(1)) begin bad++; $display("FAIL rand_b cyc%0d: got %h want %h", i, obs_b, exp_vec(1)); end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    lv_a = '0;
    lv_b = '0;
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_sel[k] = 0; m_pc[k] = 0; m_step[k] = 0; m_wrap[k] = 0;
    end
    #2;
    test_reset();
    test_free_run();
    test_pause_resume();
    test_load_clamp();
    test_priority();
    test_fast();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/light_step_sequencer.md
# light_step_sequencer

Sequential controller that generates the 6-bit `sel` index consumed by the light-line decoders (the `LightManagerN` family) in the light display path. It divides the system clock into a step rate and steps `sel` through 0..SEL_MAX, wrapping to 0. Software-style controls are provided for start, pause, stop and load. All decoders share its `sel` bus, so every light line advances in lock-step.

## Interface
- `TICK_DIV`, default 50_000_000: clock cycles per `sel` step; legal range ≥1.
- `SEL_MAX`, default 59: last `sel` value before wrap; legal range 1..63.
- `clk`  in  1  single system clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  level-sampled; IDLE→RUN, or PAUSED→RUN (resume).
- `pause`  in  1  level-sampled; RUN→PAUSED.
- `stop`  in  1  level-sampled; any state→IDLE, clears `sel`.
- `load`  in  1  level-sampled; writes `load_val` into `sel`.
- `load_val`  in  6  value for `load`.
- `sel`  out  6  registered index to the light decoders.
- `step`  out  1  one-cycle pulse, coincident with each `sel` increment.
- `wrap`  out  1  one-cycle pulse, coincident with `sel` going SEL_MAX→0.
- `busy`  out  1  high when state is RUN.
- `state`  out  2  IDLE=0, RUN=1, PAUSED=2 (3 unused).

## Operation
- Reset values: `sel`=0, `step`=0, `wrap`=0, `busy`=0, `state`=IDLE, internal prescaler `pcnt`=0.
- Per-cycle priority: `rst` > `stop` > `load` > `pause` > `start`.
  - A lower-priority control is ignored in any cycle where a higher one is asserted.
  - Exception: `load` coexists with `pause`/`start`. Both take effect in the same cycle.
- IDLE:
  - `pcnt` is held at 0.
  - `start` → RUN, `pcnt`=0, `sel` unchanged.
- RUN:
  - If `pcnt`≠TICK_DIV−1: `pcnt` increments.
  - Else: `pcnt`←0, `sel` advances and `step`←1.
  - Advance rule: `sel`←`sel`+1, except `sel`=SEL_MAX → 0 with `wrap`←1.
  - `pause` → PAUSED. That cycle does not advance `pcnt` or `sel`.
  - `start` is a no-op in RUN.
- PAUSED:
  - `pcnt` and `sel` are frozen.
  - `start` → RUN. `pcnt` resumes from its frozen value; it is not cleared.
- `stop` (any state): → IDLE, `sel`=0, `pcnt`=0, no `step`/`wrap`.
- `load` (any state):
  - `sel`←min(`load_val`, SEL_MAX) and `pcnt`←0. No `step`/`wrap` pulse.
  - State is unchanged unless `pause`/`start` also apply.
- `step`/`wrap` are 0 in every cycle not described above.
- `busy` = (`state`==RUN), registered.
- Arithmetic widths:
  - `pcnt` width is clog2(TICK_DIV), minimum 1 bit.
  - `sel` never exceeds SEL_MAX. There is no 6-bit overflow path.
- TICK_DIV=1: `sel` advances every RUN cycle.
- Reset mid-count: all state returns to reset values on the next edge, regardless of other inputs.

## Timing
- Controls are sampled at edge E and take effect in the registers updated at E.
- `start` at E0 from IDLE: first `sel` increment and `step` pulse are visible after edge E0+TICK_DIV. Subsequent steps follow every TICK_DIV cycles.
- Pause/resume: pause with `pcnt`=p, then `start` at edge R. Next step is visible after edge R+(TICK_DIV−p).
- `sel`, `step` and `wrap` change on the same edge. The decoders see the new `sel` combinationally in that cycle.
- Latency from any control to outputs: 1 edge. No combinational input→output paths.

## Structure
- Shared package `light_pkg`:
  - `SEL_W`=6.
  - Default `SEL_MAX`=59.
  - State enum/encodings IDLE/RUN/PAUSED.
- One sub-module: `tick_prescaler`.
  - Holds the `pcnt` counter with enable/clear/terminal-count output.
  - Parameter TICK_DIV.
- FSM and `sel` register stay in the top level.

## Test plan
Run with TICK_DIV=4, SEL_MAX=59 unless noted.
- Reset: assert `rst` 2 cycles with `start`=1 → `sel`=0, `state`=0, `busy`=0, `step`=`wrap`=0. Start is ignored.
- Free run: `start` at E0 → `sel`=1 after E0+4 with one `step` pulse, then `sel`=2 after E0+8. After 60 steps, `sel`=0 with `wrap`=1 for exactly one cycle.
- Pause/resume: pause when `pcnt`=2 at `sel`=5; hold 10 cycles → `sel` stays 5. `start` at R → `sel`=6 after R+2.
- Load/clamp:
  - `load`, `load_val`=57 while RUN → `sel`=57, no pulse, next step 4 cycles later.
  - `load_val`=63 → `sel`=59. Next step gives `sel`=0 with `wrap`=1.
- Priority:
  - `stop`+`load`(`load_val`=30) in RUN at `sel`=12 → `sel`=0, IDLE.
  - `start`+`pause` in IDLE → stays IDLE.
- TICK_DIV=1, SEL_MAX=3: start → `sel` 1,2,3,0,1 on consecutive cycles, `step` constantly 1, `wrap` on the 3→0 cycle.
